// File: rtl/ervp_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ervp_fifo_write_arbiter
// Brief    : Round-robin write arbiter feeding a single-entry tagged buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ervp_fifo_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BW_DATA = 32,
    parameter int BW_TAG  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [NUM_REQ-1:0]         wrequest_list,
    input  logic [NUM_REQ*BW_DATA-1:0] wdata_list,
    output logic [NUM_REQ-1:0]         wgrant_list,
    output logic                       rready,
    output logic                       rempty,
    input  logic                       rrequest,
    output logic [BW_DATA-1:0]         rdata,
    output logic [BW_TAG-1:0]          rtag,
    output logic [BW_TAG-1:0]          rr_ptr
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [BW_TAG:0]   C_NUM_REQ  = (BW_TAG+1)'(NUM_REQ);
    localparam logic [BW_TAG-1:0] C_LAST_REQ = BW_TAG'(NUM_REQ-1);

    state_t               state_q, state_d;
    logic [BW_DATA-1:0]   rdata_q, rdata_d;
    logic [BW_TAG-1:0]    rtag_q, rtag_d;
    logic [BW_TAG-1:0]    rr_ptr_q, rr_ptr_d;

    logic [2*NUM_REQ-1:0] w_req_rot;
    logic [BW_TAG-1:0]    w_offset;
    logic [BW_TAG:0]      w_sum;
    logic [BW_TAG-1:0]    w_gnt_idx;
    logic [BW_DATA-1:0]   w_gnt_data;
    logic                 w_req_any;
    logic                 w_wq;
    logic                 w_grant;
    logic                 w_pop;

    assign w_wq    = enable & ~clear & ~rst & (state_q == ST_EMPTY);
    assign w_grant = w_wq & w_req_any;
    assign w_pop   = rrequest & (state_q == ST_FULL) & enable & ~clear;

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
    assign w_req_rot = {wrequest_list, wrequest_list} >> rr_ptr_q;

    always_comb begin
        w_req_any = 1'b0;
        w_offset  = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_req_any = 1'b1;
                w_offset  = BW_TAG'(k);
            end
        end
        w_sum = {1'b0, rr_ptr_q} + {1'b0, w_offset};
        if (w_sum >= C_NUM_REQ) begin
            w_sum = w_sum - C_NUM_REQ;
        end
        w_gnt_idx   = w_sum[BW_TAG-1:0];
        w_gnt_data  = '0;
        wgrant_list = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_idx == BW_TAG'(k)) begin
                w_gnt_data     = wdata_list[k*BW_DATA +: BW_DATA];
                wgrant_list[k] = w_grant;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        rtag_d   = rtag_q;
        rr_ptr_d = rr_ptr_q;
        if (clear) begin
            state_d = ST_EMPTY;
        end else if (w_grant) begin
            state_d  = ST_FULL;
            rdata_d  = w_gnt_data;
            rtag_d   = w_gnt_idx;
            rr_ptr_d = (w_gnt_idx == C_LAST_REQ) ? '0 : w_gnt_idx + 1'b1;
        end else if (w_pop) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            rdata_q  <= '0;
            rtag_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rtag_q   <= rtag_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rready = (state_q == ST_FULL);
    assign rempty = ~rready;
    assign rdata  = rdata_q;
    assign rtag   = rtag_q;
    assign rr_ptr = rr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_ervp_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ervp_fifo_write_arbiter
// Brief    : Scoreboard bench with a behavioural model of the arbiter/buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ervp_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int BD = 32;
    localparam int BT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            clear = 1'b0;
    logic [N-1:0]    wrequest_list = '0;
    logic [N*BD-1:0] wdata_list = '0;
    logic [N-1:0]    wgrant_list;
    logic            rready;
    logic            rempty;
    logic            rrequest = 1'b0;
    logic [BD-1:0]   rdata;
    logic [BT-1:0]   rtag;
    logic [BT-1:0]   rr_ptr;

    ervp_fifo_write_arbiter #(.NUM_REQ(N), .BW_DATA(BD), .BW_TAG(BT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .wrequest_list(wrequest_list), .wdata_list(wdata_list),
        .wgrant_list(wgrant_list), .rready(rready), .rempty(rempty),
        .rrequest(rrequest), .rdata(rdata), .rtag(rtag), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BD-1:0] d;
        int            t;
    } item_t;

    item_t         expq[$];
    int            checks = 0;
    int            errors = 0;
    logic [BD-1:0] wd[N];
    logic [N-1:0]  pend = '0;

    // Reference model: buffer occupancy, pointer and stored word.
    bit            m_full = 0;
    int            m_ptr  = 0;
    logic [BD-1:0] m_data = '0;
    int            m_tag  = 0;
    int            last_g = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drives one cycle, checks outputs against the model, advances the model.
    task automatic step(input logic [N-1:0] req, input logic rq, input logic en,
                        input logic cl, input logic rs);
        int            g;
        logic [N-1:0]  eg;
        item_t         it;
        wrequest_list = req;
        rrequest      = rq;
        enable        = en;
        clear         = cl;
        rst           = rs;
        for (int i = 0; i < N; i++) wdata_list[i*BD +: BD] = wd[i];
        #1;
        g = -1;
        if (!rs && en && !cl && !m_full) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && req[j]) g = j;
            end
        end
        eg = (g >= 0) ? N'(1 << g) : '0;
        chk("wgrant", 32'(wgrant_list), 32'(eg));
        chk("rr_ptr", 32'(rr_ptr), m_ptr);
        chk("rready", 32'(rready), 32'(m_full));
        chk("rempty", 32'(rempty), 32'(!m_full));
        chk("rdata", rdata, m_data);
        chk("rtag", 32'(rtag), m_tag);
        last_g = g;
        if (rs) begin
            m_full = 0; m_ptr = 0; m_data = '0; m_tag = 0;
        end else if (cl) begin
            m_full = 0;
        end else if (g >= 0) begin
            m_full = 1; m_data = wd[g]; m_tag = g; m_ptr = (g + 1) % N;
            it.d = wd[g]; it.t = g;
            expq.push_back(it);
        end else if (en && rq && m_full) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    // Monitor: every newly presented word must match the oldest expected one.
    initial begin
        logic  prev_rdy;
        item_t it;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rready === 1'b1 && !prev_rdy) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual_tag=%0d required=none", rtag);
                end else begin
                    it = expq.pop_front();
                    chk("sb_rdata", rdata, it.d);
                    chk("sb_rtag", 32'(rtag), it.t);
                end
            end
            prev_rdy = (rready === 1'b1);
        end
    end

    initial begin
        for (int i = 0; i < N; i++) wd[i] = 32'hA0 + 32'(i);
        @(negedge clk);
        // Reset and idle
        repeat (2) step('0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) step('0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Round-robin fairness with eager consumer
        repeat (12) step(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
        step('0, 1'b1, 1'b1, 1'b1, 1'b0);
        // Pointer to 3, then skip/wrap with requesters 1 and 2
        step(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
        // Backpressure with requester 2's word held
        step(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) step(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'b1001, 1'b1, 1'b1, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        // Clear while full with a pop request
        step(4'b1001, 1'b1, 1'b1, 1'b1, 1'b0);
        // Enable low while empty and while full
        repeat (3) step(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        // Reset in a cycle that would otherwise grant requester 1
        step(4'b0010, 1'b0, 1'b1, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        // Randomized traffic; requesters hold until granted, occasionally give up
        for (int c = 0; c < 3000; c++) begin
            logic en, cl, rs;
            for (int i = 0; i < N; i++) begin
                if (last_g == i) pend[i] = 1'b0;
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    wd[i]   = $urandom;
                end else if (pend[i] && ($urandom % 40 == 0)) begin
                    pend[i] = 1'b0;
                end
            end
            cl = ($urandom % 16 == 0);
            en = cl ? 1'b1 : ($urandom % 8 != 0);
            rs = ($urandom % 250 == 0);
            step(pend, 1'($urandom % 2), en, cl, rs);
        end
        step('0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ervp_fifo_write_arbiter.md
# ervp_fifo_write_arbiter

Round-robin write arbiter with an integrated single-entry buffer. It lets NUM_REQ producers share one single-entry FIFO stage that drains to a single consumer. Each accepted word is stored with the index of the requester that wrote it. The block sits between several producer engines and one downstream consumer port, and uses the same wrequest/rready/rempty/rrequest handshake style as the rest of the memory library.

## Interface
Parameters:
- NUM_REQ, 4: number of write requesters; must be ≥2.
- BW_DATA, 32: data width per requester.
- BW_TAG, 2: width of the source-index tag; must satisfy NUM_REQ ≤ 2^BW_TAG.

Ports:
- clk  in  1  the only clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- enable  in  1  when 0, state, pointer and buffer hold their values.
- clear  in  1  synchronous flush; has priority over all traffic except rst.
- wrequest_list  in  NUM_REQ  per-requester write request; bit i belongs to requester i.
- wdata_list  in  NUM_REQ*BW_DATA  requester i's data in bits [i*BW_DATA +: BW_DATA].
- wgrant_list  out  NUM_REQ  one-hot, combinational; bit i=1 means requester i's word is captured at this edge.
- rready  out  1  buffer holds a valid word.
- rempty  out  1  equals ~rready.
- rrequest  in  1  consumer pop request.
- rdata  out  BW_DATA  stored word; registered.
- rtag  out  BW_TAG  index of the requester that wrote rdata; registered.
- rr_ptr  out  BW_TAG  current highest-priority requester index (status/debug).

## Operation
- State machine with two states, EMPTY and FULL. rready = (state==FULL).
- Write qualifier: wq = enable & ~clear & (state==EMPTY).
- Grant selection: if wq is 1, the block scans requesters starting at rr_ptr and wrapping cyclically through NUM_REQ-1 and then 0. The first i found with wrequest_list[i]=1 receives wgrant_list[i]=1. All other grant bits are 0. If wq is 0, wgrant_list is all 0.
- On any grant to requester g:
  - rdata ← wdata_list[g]
  - rtag ← g
  - state → FULL
  - rr_ptr ← (g==NUM_REQ-1) ? 0 : g+1. This wraps correctly when NUM_REQ is not a power of two.
- Pop: pop = rrequest & rready & enable & ~clear. On pop, state → EMPTY. rdata and rtag keep their last values and are not zeroed.
- No bypass and no concurrent write/read: a write occurs only in EMPTY and a pop only in FULL. Peak throughput is therefore one word per 2 cycles.
- The pointer advances only on a grant. It does not move when there are no requests or while the buffer is FULL.
- Requesters hold wrequest and wdata stable until granted. A deasserted request simply loses its turn; the block keeps no memory of it.
- clear: state → EMPTY, and any buffered word is discarded. rr_ptr, rdata and rtag are unchanged. No grant and no pop occur in a clear cycle.
- enable=0: no grants, no pops, and all registers hold. rready still reflects the state, but a consumer must not treat rrequest as accepted in that cycle.

## Timing
- Reset values (rst=1 at an edge): state EMPTY, rready 0, rempty 1, rdata 0, rtag 0, rr_ptr 0, wgrant_list 0 combinationally while state is EMPTY with no requests.
- rst asserted mid-operation drops any buffered word at that edge. No grant is issued in a cycle where rst is sampled high; wgrant_list is forced to 0 while rst=1.
- Latency from a grant at edge N to rready=1, with rdata and rtag valid, is 1 cycle: visible after edge N.
- Pop at edge N gives rready=0 after N. The earliest next grant is at edge N+1.
- wgrant_list is combinational from wrequest_list, rr_ptr, state, enable, clear and rst. There is no combinational path from rrequest to wgrant_list.

## Test plan
- Reset and idle:
  - Stimulus: assert rst for 2 cycles, then hold all wrequest low for 5 cycles.
  - Required: rempty=1, rready=0, rdata=0, rtag=0, rr_ptr=0, wgrant_list=0 throughout.
- Round-robin fairness:
  - Stimulus: NUM_REQ=4, requesters 0–3 all request continuously with data 0xA0+i; the consumer pops every cycle it can.
  - Required: tags appear in the order 0,1,2,3,0,1; one word every 2 cycles; rdata=0xA0+rtag each time.
- Pointer skip and wrap:
  - Stimulus: rr_ptr=3; only requesters 1 and 2 request.
  - Required: requester 1 is granted first (3→0→1), rr_ptr becomes 2, and requester 2 is granted next.
- Backpressure:
  - Stimulus: a word from requester 2 is buffered; rrequest stays low for 10 cycles while requesters 0 and 3 request.
  - Required: wgrant_list=0 for all 10 cycles, rdata and rtag stable at requester 2's values, rr_ptr=3. After the pop, requester 3 is granted.
- Clear and enable:
  - Stimulus: clear while FULL with rrequest=1.
  - Required: rempty=1 after the edge, no pop is counted, rr_ptr is unchanged, and wgrant_list=0 in the clear cycle.
  - Stimulus: enable=0 with pending requests.
  - Required: no grant and all registers hold.
- Reset mid-transfer:
  - Stimulus: rst=1 in the same cycle that requester 1 would be granted while EMPTY.
  - Required: wgrant_list=0, and state EMPTY, rr_ptr=0, rtag=0 afterwards.
